axis_pkt_gen: RTL and testbench

//  Descriptor-driven AXI-Stream packet transmitter; the producer that feeds an AXIS FIFO's slave port.

---
 rtl/axis_pkt_gen.sv | 214 +++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// axis_pkt_gen
//
// Descriptor-driven AXI-Stream packet transmitter. Accepts one descriptor
// (byte length + 32-bit seed) at a time. It emits the packet as DATA_WIDTH-wide
// beats. Each beat carries an incrementing 32-bit lane pattern, and tkeep and
// tlast are set correctly for the packet length.
//
// Lane i (bits 32i+:32) of beat b carries seed + b*(DATA_WIDTH/32) + i (mod 2^32).
// The final beat keeps the low (len mod KEEP_WIDTH) bytes, or all bytes when the
// length is an exact multiple of KEEP_WIDTH. A zero-length descriptor is
// dropped. It raises len_err for one cycle.
//
// Ports
//   aclk          in   1           clock
//   sync_rst      in   1           synchronous reset, active-high
//   desc_valid    in   1           descriptor valid
//   desc_len      in   LEN_WIDTH   packet length in bytes
//   desc_seed     in   32          value of lane 0 of beat 0
//   desc_ready    out  1           descriptor accepted when desc_valid & desc_ready
//   m_axis_valid  out  1           AXIS beat valid
//   m_axis_data   out  DATA_WIDTH  AXIS data
//   m_axis_last   out  1           final beat of packet
//   m_axis_keep   out  KEEP_WIDTH  byte enables
//   m_axis_ready  in   1           AXIS sink ready
//   pkt_cnt       out  32          packets completed, wraps at 2^32
//   len_err       out  1           one-cycle pulse: zero-length descriptor dropped
//
// All outputs come straight from registers. The next-state logic may look at
// m_axis_ready, but m_axis_valid is never a combinational function of it.
// -----------------------------------------------------------------------------
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  sync_rst,
    input  logic                  desc_valid,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic [31:0]           desc_seed,
    output logic                  desc_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    output logic [KEEP_WIDTH-1:0] m_axis_keep,
    input  logic                  m_axis_ready,
    output logic [31:0]           pkt_cnt,
    output logic                  len_err
);

    localparam int LANES = DATA_WIDTH / 32;
    localparam int REM_W = LEN_WIDTH + 1;

    // One extra bit makes len + KEEP_WIDTH - 1 fit without overflow when the
    // length is at its maximum.
    localparam logic [REM_W-1:0]     KEEP_W    = REM_W'(KEEP_WIDTH);
    localparam logic [REM_W-1:0]     KEEP_M1   = REM_W'(KEEP_WIDTH - 1);
    localparam logic [REM_W-1:0]     ONE_REM   = REM_W'(1);
    localparam logic [LEN_WIDTH-1:0] ONE_LEN   = LEN_WIDTH'(1);
    localparam logic [31:0]          LANE_STEP = 32'(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q,   state_d;
    logic                  rdy_q,     rdy_d;
    logic                  valid_q,   valid_d;
    logic                  last_q,    last_d;
    logic [KEEP_WIDTH-1:0] keep_q,    keep_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    // Beats still to send after the one on the bus. The beat on the bus is
    // final when this reaches zero. The counter is LEN_WIDTH bits wide. That
    // is well above ceil(max_len/KEEP_WIDTH) - 1.
    logic [LEN_WIDTH-1:0]  left_q,    left_d;
    // Keep mask for the final beat. It is computed once, at accept time.
    logic [KEEP_WIDTH-1:0] tail_q,    tail_d;
    logic [31:0]           cnt_q,     cnt_d;
    logic                  err_q,     err_d;

    logic [REM_W-1:0]      len_ext;
    logic [REM_W-1:0]      len_rem;
    logic [LEN_WIDTH-1:0]  beats_m1;
    logic [KEEP_WIDTH-1:0] tail_mask;

    // Low rem bytes enabled. A zero remainder means the final beat is full.
    function automatic logic [KEEP_WIDTH-1:0] tail_keep(input logic [REM_W-1:0] rem);
        logic [KEEP_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            m[k] = (rem == '0) || (REM_W'(k) < rem);
        end
        return m;
    endfunction

    // Descriptor decode. The beat count is ceil(len / KEEP_WIDTH). The
    // constant divisor keeps this a fixed network.
    always_comb begin
        len_ext   = {1'b0, desc_len};
        len_rem   = len_ext % KEEP_W;
        beats_m1  = LEN_WIDTH'(((len_ext + KEEP_M1) / KEEP_W) - ONE_REM);
        tail_mask = tail_keep(len_rem);
    end

    // Next-state and next-output logic.
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        valid_d = valid_q;
        last_d  = last_q;
        keep_d  = keep_q;
        data_d  = data_q;
        left_d  = left_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                // The registered ready is the one the producer sees. Gating the
                // accept with it means no descriptor is taken in the cycle
                // right after reset release.
                if (desc_valid && rdy_q) begin
                    if (desc_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SEND;
                        rdy_d   = 1'b0;
                        valid_d = 1'b1;
                        left_d  = beats_m1;
                        tail_d  = tail_mask;
                        last_d  = (beats_m1 == '0);
                        keep_d  = (beats_m1 == '0) ? tail_mask : '1;
                        for (int i = 0; i < LANES; i++) begin
                            data_d[32*i +: 32] = desc_seed + 32'(i);
                        end
                    end
                end
            end

            SEND: begin
                // valid_q is always set in SEND, so ready alone marks a handshake.
                if (m_axis_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        keep_d  = '0;
                        cnt_d   = cnt_q + 32'd1;
                    end else begin
                        left_d = left_q - ONE_LEN;
                        last_d = (left_q == ONE_LEN);
                        keep_d = (left_q == ONE_LEN) ? tail_q : '1;
                        // Every lane moves forward by one beat's worth of lanes.
                        for (int i = 0; i < LANES; i++) begin
                            data_d[32*i +: 32] = data_q[32*i +: 32] + LANE_STEP;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples its pre-edge value and there is no ordering race between
    // processes.
    always_ff @(posedge aclk) begin
        if (sync_rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            keep_q  <= '0;
            // NOTE: the wide data register is reset on purpose. The bus must
            // read all zeros after reset, not whatever the last packet left.
            data_q  <= '0;
            left_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            keep_q  <= keep_d;
            data_q  <= data_d;
            left_q  <= left_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign desc_ready   = rdy_q;
    assign m_axis_valid = valid_q;
    assign m_axis_data  = data_q;
    assign m_axis_last  = last_q;
    assign m_axis_keep  = keep_q;
    assign pkt_cnt      = cnt_q;
    assign len_err      = err_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_gen
//
// Self-checking bench for axis_pkt_gen with the default 512-bit configuration.
// The descriptor driver pushes the expected beats of each packet into a queue.
// A monitor at the falling edge pops one entry per AXIS handshake and compares
// it with the bus. It also checks hold-during-stall, idle outputs and the
// inter-packet bubble.
// -----------------------------------------------------------------------------
module tb_axis_pkt_gen;

    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int LW    = 16;
    localparam int LANES = DW / 32;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          aclk;
    logic          sync_rst;
    logic          desc_valid;
    logic [LW-1:0] desc_len;
    logic [31:0]   desc_seed;
    logic          desc_ready;
    logic          m_axis_valid;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_last;
    logic [KW-1:0] m_axis_keep;
    logic          m_axis_ready = 1'b0;
    logic [31:0]   pkt_cnt;
    logic          len_err;

    axis_pkt_gen #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .LEN_WIDTH  (LW)
    ) dut (
        .aclk         (aclk),
        .sync_rst     (sync_rst),
        .desc_valid   (desc_valid),
        .desc_len     (desc_len),
        .desc_seed    (desc_seed),
        .desc_ready   (desc_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .m_axis_keep  (m_axis_keep),
        .m_axis_ready (m_axis_ready),
        .pkt_cnt      (pkt_cnt),
        .len_err      (len_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail   = 0;
    beat_t       exp_q[$];
    logic [31:0] exp_cnt  = '0;
    logic        mon_en   = 1'b0;
    logic        rand_ready  = 1'b0;
    logic        ready_fixed = 1'b1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink ready is updated just after each rising edge.
    always @(posedge aclk) begin
        #1;
        m_axis_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Reference model: the expected beats of one packet.
    task automatic push_pkt(input int len, input logic [31:0] seed);
        int nb;
        int rem;
        beat_t bt;
        nb  = (len + KW - 1) / KW;
        rem = len % KW;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < LANES; i++) begin
                bt.data[32*i +: 32] = seed + 32'(b * LANES + i);
            end
            bt.last = (b == nb - 1);
            if (bt.last && rem != 0) bt.keep = (KW'(1) << rem) - KW'(1);
            else                     bt.keep = '1;
            exp_q.push_back(bt);
        end
    endtask

    // Offers one descriptor and holds it until accepted. It returns #1 into the
    // cycle after acceptance, which is when beat 0 must be on the bus.
    task automatic send_desc(input int len, input logic [31:0] seed);
        bit taken;
        taken      = 1'b0;
        desc_len   = LW'(len);
        desc_seed  = seed;
        desc_valid = 1'b1;
        for (int c = 0; c < 3000 && !taken; c++) begin
            if (desc_ready) begin
                taken = 1'b1;
                if (len != 0) begin
                    push_pkt(len, seed);
                    exp_cnt = exp_cnt + 32'd1;
                end
            end
            @(posedge aclk);
            #1;
        end
        desc_valid = 1'b0;
        if (!taken) check("desc_accept", desc_ready, 1);
        else begin
            check("beat0_latency", m_axis_valid, (len != 0));
            check("len_err_pulse", len_err, (len == 0));
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 5000; c++) begin
            if (exp_q.size() == 0 && !m_axis_valid) break;
            @(posedge aclk);
            #1;
        end
        check("drain", (exp_q.size() == 0 && !m_axis_valid), 1);
        check("pkt_cnt", pkt_cnt, exp_cnt);
    endtask

    // Bus monitor / scoreboard, sampled mid-cycle.
    logic          stall_pending = 1'b0;
    logic          chk_rdy_next  = 1'b0;
    logic [DW-1:0] st_data;
    logic [KW-1:0] st_keep;
    logic          st_last;

    always @(negedge aclk) begin
        beat_t e;
        if (!mon_en) begin
            stall_pending = 1'b0;
            chk_rdy_next  = 1'b0;
        end else begin
            if (chk_rdy_next) begin
                check("rdy_after_last", desc_ready, 1);
                check("bubble", m_axis_valid, 0);
            end
            if (stall_pending) begin
                check("stall_valid", m_axis_valid, 1);
                check("stall_data", m_axis_data, st_data);
                check("stall_keep", m_axis_keep, st_keep);
                check("stall_last", m_axis_last, st_last);
            end
            if (m_axis_valid) begin
                check("rdy_low_in_send", desc_ready, 0);
            end else begin
                check("idle_keep", m_axis_keep, 0);
                check("idle_last", m_axis_last, 0);
            end
            chk_rdy_next = 1'b0;
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", m_axis_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_data, e.data);
                    check("beat_keep", m_axis_keep, e.keep);
                    check("beat_last", m_axis_last, e.last);
                    chk_rdy_next = m_axis_last;
                end
            end
            stall_pending = m_axis_valid && !m_axis_ready;
            st_data = m_axis_data;
            st_keep = m_axis_keep;
            st_last = m_axis_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sync_rst   = 1'b1;
        desc_valid = 1'b0;
        desc_len   = '0;
        desc_seed  = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_valid", m_axis_valid, 0);
        check("rst_last", m_axis_last, 0);
        check("rst_keep", m_axis_keep, 0);
        check("rst_data", m_axis_data, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_len_err", len_err, 0);
        check("rst_desc_ready", desc_ready, 0);
        sync_rst = 1'b0;
        @(posedge aclk);
        #1;
        check("rdy_after_reset", desc_ready, 1);
        mon_en = 1'b1;

        // 1: single full beat.
        send_desc(64, 32'h100);
        check("t1_lane0", m_axis_data[31:0], 32'h100);
        check("t1_lane15", m_axis_data[511:480], 32'h10F);
        check("t1_keep", m_axis_keep, {KW{1'b1}});
        check("t1_last", m_axis_last, 1);
        wait_idle();

        // 2: three beats, partial tail.
        send_desc(130, 32'h0);
        check("t2_beat0_last", m_axis_last, 0);
        wait_idle();

        // 3: zero length is dropped, then a normal descriptor.
        send_desc(0, 32'hDEAD_BEEF);
        check("t3_no_valid", m_axis_valid, 0);
        @(posedge aclk);
        #1;
        check("t3_len_err_one_cycle", len_err, 0);
        check("t3_still_no_valid", m_axis_valid, 0);
        check("t3_pkt_cnt", pkt_cnt, exp_cnt);
        send_desc(64, 32'h2000);
        wait_idle();

        // 4: random back-pressure, back-to-back descriptors.
        rand_ready = 1'b1;
        send_desc(256, 32'hABCD_0000);
        wait_idle();
        send_desc(200, 32'h1234_5678);
        send_desc(1, 32'h8000_0000);
        send_desc(129, 32'h0000_0FF0);
        wait_idle();
        rand_ready = 1'b0;

        // 5: reset during beat 1 of a three-beat packet.
        send_desc(150, 32'h700);
        @(posedge aclk);
        #1;
        check("t5_beat1_on_bus", m_axis_data[31:0], 32'h710);
        mon_en   = 1'b0;
        sync_rst = 1'b1;
        @(posedge aclk);
        #1;
        check("t5_valid_dropped", m_axis_valid, 0);
        check("t5_pkt_cnt_cleared", pkt_cnt, 0);
        check("t5_rdy_in_reset", desc_ready, 0);
        sync_rst = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        @(posedge aclk);
        #1;
        check("t5_rdy_after_release", desc_ready, 1);
        mon_en = 1'b1;
        send_desc(100, 32'h55);
        wait_idle();

        // 6: lane pattern wraps at 2^32.
        send_desc(64, 32'hFFFF_FFF8);
        check("t6_lane7", m_axis_data[255:224], 32'hFFFF_FFFF);
        check("t6_lane8", m_axis_data[287:256], 32'h0000_0000);
        wait_idle();

        // Maximum length: 1024 beats, last keeps 63 bytes.
        send_desc(65535, 32'h1);
        wait_idle();

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
